// File: rtl/warpv_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : warpv_reset_ctrl
// Brief   : Per-tile WarpV reset sequencer (POR / SW / WDT, quiesce, staged release)
// Revision: 1.0
// ============================================================================
module warpv_reset_ctrl #(
  parameter int HOLD_CYCLES    = 16,
  parameter int RELEASE_STAGES = 4,
  parameter int DRAIN_TIMEOUT  = 256,
  parameter int CNT_W          = 9
) (
  input  logic       gclk,
  input  logic       rst_n,
  input  logic       sw_rst_req,
  input  logic       wdt_expire,
  input  logic       core_idle,
  output logic       core_rst_n,
  output logic       quiesce_req,
  output logic       rst_busy,
  output logic       rst_done,
  output logic [1:0] rst_cause,
  output logic       drain_timeout
);

  localparam logic [1:0] c_ST_HOLD    = 2'd0;
  localparam logic [1:0] c_ST_RELEASE = 2'd1;
  localparam logic [1:0] c_ST_RUN     = 2'd2;
  localparam logic [1:0] c_ST_QUIESCE = 2'd3;

  localparam logic [1:0] c_CAUSE_SW  = 2'd1;
  localparam logic [1:0] c_CAUSE_WDT = 2'd2;

  localparam logic [CNT_W-1:0] c_HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_REL_LAST   = CNT_W'(RELEASE_STAGES - 1);
  localparam logic [CNT_W-1:0] c_DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

  logic [1:0]       r_sync;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;

  logic             w_rst_sync;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_cause_nxt;
  logic             w_dto_nxt;

  assign w_rst_sync = r_sync[1];

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = rst_cause;
    w_dto_nxt   = drain_timeout;
    case (r_state)
      c_ST_HOLD: begin
        if (!w_rst_sync) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_HOLD_LAST) begin
          w_state_nxt = c_ST_RELEASE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      c_ST_RELEASE: begin
        if (r_cnt == c_REL_LAST) begin
          w_state_nxt = c_ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      c_ST_RUN: begin
        w_cnt_nxt = '0;
        if (wdt_expire || sw_rst_req) begin
          w_state_nxt = c_ST_QUIESCE;
          w_dto_nxt   = 1'b0;
          w_cause_nxt = wdt_expire ? c_CAUSE_WDT : c_CAUSE_SW;
        end
      end
      c_ST_QUIESCE: begin
        // A drained core takes precedence over a coincident timeout.
        if (core_idle) begin
          w_state_nxt = c_ST_HOLD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_DRAIN_LAST) begin
          w_state_nxt = c_ST_HOLD;
          w_cnt_nxt   = '0;
          w_dto_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = c_ST_HOLD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every port is a plain flop.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_ST_HOLD;
      r_cnt         <= '0;
      core_rst_n    <= 1'b0;
      quiesce_req   <= 1'b0;
      rst_busy      <= 1'b1;
      rst_done      <= 1'b0;
      rst_cause     <= 2'd0;
      drain_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      core_rst_n    <= (w_state_nxt == c_ST_RUN) || (w_state_nxt == c_ST_QUIESCE);
      quiesce_req   <= (w_state_nxt == c_ST_QUIESCE);
      rst_busy      <= (w_state_nxt != c_ST_RUN);
      rst_done      <= (w_state_nxt == c_ST_RUN) && (r_state != c_ST_RUN);
      rst_cause     <= w_cause_nxt;
      drain_timeout <= w_dto_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/warpv_reset_ctrl.md
Name: warpv_reset_ctrl

Overview:
- Per-tile reset sequencer for the WarpV core; it sits upstream of the core's reset synchroniser and drives the core reset line.
- Combines three reset sources: power-on (chip rst_n), software reset request, and watchdog expiry.
- For software and watchdog resets, it first asks the core to quiesce, with a timeout, then holds reset for a minimum width and releases it in a staged, synchronous way.
- Reports reset cause, busy and done status to tile config/debug logic.

Parameters:
HOLD_CYCLES, 16, cycles core_rst_n is held low after the sequencer's own reset synchroniser is released (>=1)
RELEASE_STAGES, 4, cycles spent in RELEASE before core_rst_n deasserts (>=1)
DRAIN_TIMEOUT, 256, maximum cycles spent in QUIESCE waiting for core_idle (>=1)
CNT_W, 9, internal counter width; must hold max(HOLD_CYCLES, RELEASE_STAGES, DRAIN_TIMEOUT)-1

Ports:
gclk  input  1  clock; all flops are posedge gclk
rst_n  input  1  chip reset; asynchronous assert, active-low
sw_rst_req  input  1  software reset request, level sampled each cycle
wdt_expire  input  1  watchdog expiry, level sampled each cycle
core_idle  input  1  core has drained outstanding NoC/memory transactions
core_rst_n  output  1  active-low reset to the core (feeds the core reset synchroniser)
quiesce_req  output  1  asks the core to stop issue and drain
rst_busy  output  1  sequence in progress (any state other than RUN)
rst_done  output  1  one-cycle pulse on the first cycle of RUN
rst_cause  output  2  last reset cause: 0 POR, 1 SW, 2 WDT (3 unused)
drain_timeout  output  1  last QUIESCE ended by timeout rather than core_idle

Behaviour:
- Reset is asynchronous, active-low on rst_n; all flops clear immediately when rst_n=0, at any time, including mid-sequence.
- Reset values:
  - state = HOLD, counter = 0, 2-flop synchroniser = 00
  - core_rst_n = 0, quiesce_req = 0, rst_busy = 1, rst_done = 0
  - rst_cause = 0, drain_timeout = 0
- Internal synchroniser: 2 flops, async-cleared by rst_n, D = 1. rst_sync goes high after the 2nd gclk edge with rst_n high.
- While rst_sync = 0 the FSM stays in HOLD with counter = 0.
- All outputs come directly from flops. No combinational path from any input to any output.
- FSM states and transitions:
  - HOLD: core_rst_n = 0, quiesce_req = 0. Counter increments each cycle. On counter == HOLD_CYCLES-1: go to RELEASE, counter = 0.
  - RELEASE: core_rst_n = 0. Counter increments. On counter == RELEASE_STAGES-1: go to RUN, counter = 0.
  - RUN: core_rst_n = 1, rst_busy = 0. rst_done = 1 on the first RUN cycle only. If wdt_expire | sw_rst_req: go to QUIESCE, counter = 0, drain_timeout = 0, rst_cause = 2 if wdt_expire else 1. WDT wins when both are high.
  - QUIESCE: core_rst_n = 1, quiesce_req = 1, rst_busy = 1.
    - If core_idle: go to HOLD.
    - Else if counter == DRAIN_TIMEOUT-1: go to HOLD with drain_timeout = 1.
    - Else counter increments.
    - core_idle wins over timeout when both occur in the same cycle.
- Latency:
  - Request sampled in RUN at edge t gives quiesce_req = 1 and rst_busy = 1 after edge t.
  - core_idle sampled at edge u gives core_rst_n = 0 and quiesce_req = 0 after edge u.
  - core_rst_n stays low exactly HOLD_CYCLES + RELEASE_STAGES cycles.
- Requests outside RUN are ignored and not queued. A level still high on re-entering RUN starts a new sequence on the next edge; rst_done still pulses.
- core_idle outside QUIESCE is ignored.
- rst_cause and drain_timeout hold their values until the next request is accepted. POR clears both to 0.
- A counter that is not compared in the current state holds 0. The counter never wraps.

Test Plan:
1. Power-on: rst_n low 5 cycles, then high at edge 1 (defaults) -> core_rst_n = 0 through edge 21, core_rst_n = 1 and rst_done = 1 after edge 22; rst_done = 0 after edge 23; rst_cause = 0.
2. SW reset: pulse sw_rst_req in RUN; core_idle rises 10 cycles after quiesce_req -> quiesce_req high 10 cycles; core_rst_n low exactly 20 cycles; rst_cause = 1; drain_timeout = 0; one rst_done pulse.
3. Drain timeout: wdt_expire with core_idle held 0 -> quiesce_req high exactly 256 cycles, then core_rst_n low 20 cycles; drain_timeout = 1; rst_cause = 2.
4. Priority and ignores:
   - sw_rst_req and wdt_expire in the same cycle -> rst_cause = 2.
   - sw_rst_req pulsed during HOLD -> no second sequence; exactly one rst_done.
   - core_idle and timeout in the same cycle -> drain_timeout = 0.
5. Async reset mid-sequence: rst_n low for 1 cycle during QUIESCE, then during RELEASE -> outputs go to reset values immediately without a clock edge; full 22-edge POR sequence reruns; rst_cause = 0.
6. Parameter corner: HOLD_CYCLES = 1, RELEASE_STAGES = 1, DRAIN_TIMEOUT = 1 -> core_rst_n low exactly 2 cycles per sequence; QUIESCE lasts exactly 1 cycle without core_idle; POR release after edge 4.
